mdu_seq: RTL and testbench

Iterative multiply/divide sequencer that owns the architectural HI/LO registers of the MIPS core. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX through a start/busy/done handshake. It runs a 32-step shift-add or restoring-divide loop over one shared 64-bit adder datapath, and commits HI/LO unless the pipeline flushes the operation.

---
 rtl/mdu_seq.sv | 170 +++++++++++++++++
 tb/tb_mdu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// 32-step shift-add multiply or restoring divide over one shared 64-bit adder.
module mdu_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] acc_hi_reg, acc_lo_reg;
    logic [31:0] opnd_reg;
    logic [31:0] a_raw_reg;
    logic [4:0]  count_reg;
    logic        is_div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;

    logic        accept, commit, last_iter;
    logic        signed_op, a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] div_shift;
    logic [63:0] add_x, add_y, sum;
    logic        add_cin, div_fits;
    logic [31:0] hi_step, lo_step, hi_fix, lo_fix;
    logic [63:0] prod, prod_neg;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Arithmetic ops are op=0xx; op[0] selects unsigned, op[1] selects divide.
    assign accept    = (state_reg == IDLE) && start && !cancel && !op[2];
    assign commit    = (state_reg == DONE) && !cancel;
    assign last_iter = (count_reg == 5'(ITER - 1));
    assign signed_op = !op[0];
    assign a_neg     = signed_op && a[31];
    assign b_neg     = signed_op && b[31];
    assign abs_a     = a_neg ? (32'd0 - a) : a;
    assign abs_b     = b_neg ? (32'd0 - b) : b;

    // Shared adder: accumulate for multiply, trial subtract for divide.
    assign div_shift = {acc_hi_reg, acc_lo_reg[31]};
    assign add_x     = is_div_reg ? {31'd0, div_shift} : {32'd0, acc_hi_reg};
    assign add_y     = is_div_reg ? ~{32'd0, opnd_reg}
                                  : (acc_lo_reg[0] ? {32'd0, opnd_reg} : 64'd0);
    assign add_cin   = is_div_reg;
    assign sum       = add_x + add_y + {63'd0, add_cin};
    // A non-negative trial difference is below 2^33, so its upper bits are all zero.
    assign div_fits  = ~|sum[63:33];

    always_comb begin
        hi_step = acc_hi_reg;
        lo_step = acc_lo_reg;
        if (is_div_reg) begin
            if (div_fits) begin
                hi_step = sum[31:0];
                lo_step = {acc_lo_reg[30:0], 1'b1};
            end else begin
                hi_step = div_shift[31:0];
                lo_step = {acc_lo_reg[30:0], 1'b0};
            end
        end else begin
            hi_step = sum[32:1];
            lo_step = {sum[0], acc_lo_reg[31:1]};
        end
    end

    assign prod     = {hi_step, lo_step};
    assign prod_neg = 64'd0 - prod;

    always_comb begin
        hi_fix = hi_step;
        lo_fix = lo_step;
        if (is_div_reg) begin
            if (div_zero_reg) begin
                hi_fix = a_raw_reg;
                lo_fix = 32'hFFFF_FFFF;
            end else begin
                hi_fix = neg_rem_reg ? (32'd0 - hi_step) : hi_step;
                lo_fix = neg_res_reg ? (32'd0 - lo_step) : lo_step;
            end
        end else if (neg_res_reg) begin
            hi_fix = prod_neg[63:32];
            lo_fix = prod_neg[31:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (cancel)         state_next = IDLE;
                else if (last_iter) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            opnd_reg     <= '0;
            a_raw_reg    <= '0;
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && start && !cancel) begin
                if (op == 3'b100) hi_reg <= a;
                if (op == 3'b101) lo_reg <= a;
            end
            if (commit) begin
                hi_reg <= acc_hi_reg;
                lo_reg <= acc_lo_reg;
            end
            if (accept) begin
                is_div_reg   <= op[1];
                neg_res_reg  <= a_neg ^ b_neg;
                neg_rem_reg  <= op[1] && a_neg;
                div_zero_reg <= op[1] && (b == 32'd0);
                a_raw_reg    <= a;
                acc_hi_reg   <= '0;
                count_reg    <= '0;
                // Divide: dividend shifts out of LO; multiply: multiplier does.
                if (op[1]) begin
                    acc_lo_reg <= abs_a;
                    opnd_reg   <= abs_b;
                end else begin
                    acc_lo_reg <= abs_b;
                    opnd_reg   <= abs_a;
                end
            end
            if (state_reg == RUN) begin
                count_reg <= count_reg + 5'd1;
                if (last_iter) begin
                    acc_hi_reg <= hi_fix;
                    acc_lo_reg <= lo_fix;
                end else begin
                    acc_hi_reg <= hi_step;
                    acc_lo_reg <= lo_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: arithmetic results, latency,
// divide by zero, MTHI/MTLO, ignored starts, cancel and mid-run reset.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_seq #(.ITER(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for done (bounded), returns the cycle number of done and busy-cycle count.
    task automatic wait_done(output int n, output int busy_cnt);
        n = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            n++;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int n, bc;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        wait_done(n, bc);
        check({tag, "_lat"}, n, 33);
        check({tag, "_busycnt"}, bc, 33);
        tick();
        check({tag, "_busy0"}, 32'(busy), 32'd0);
        check({tag, "_done0"}, 32'(done), 32'd0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        $display("op %s: op=%0d hi=%h lo=%h latency=%0d", tag, o, hi, lo, n);
    endtask

    initial begin
        int n, bc;
        resetn = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        resetn = 1'b1;
        tick();

        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        tick();
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'b101; a = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_busy", 32'(busy), 32'd0);
        $display("mthi/mtlo: hi=%h lo=%h", hi, lo);

        do_op("mult",   3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu",  3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
        do_op("divu",   3'b011, 32'd100,       32'd7,         32'd2,         32'd14);
        do_op("div",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_ov", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_op("divu_0", 3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        do_op("div_0",  3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // MTLO issued during cycle 5 of a running DIVU must be dropped.
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("busy_start_lo", lo, 32'hFFFF_FFFF);
        wait_done(n, bc);
        check("busy_start_lat", n, 33 - 5);
        tick();
        check("busy_start_hi2", hi, 32'd2);
        check("busy_start_lo2", lo, 32'd14);
        $display("start-while-busy: hi=%h lo=%h", hi, lo);

        // Cancel in RUN cycle 10.
        start = 1'b1; op = 3'b000; a = 32'd1000; b = 32'd1000;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_run_busy", 32'(busy), 32'd0);
        check("cxl_run_done", 32'(done), 32'd0);
        n = 0;
        repeat (30) begin
            tick();
            if (done === 1'b1) n++;
        end
        check("cxl_run_nodone", n, 0);
        check("cxl_run_hi", hi, 32'd2);
        check("cxl_run_lo", lo, 32'd14);
        $display("cancel in RUN: busy=%0d hi=%h lo=%h", busy, hi, lo);

        // Cancel in the DONE cycle suppresses the commit.
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        wait_done(n, bc);
        check("cxl_done_lat", n, 33);
        check("cxl_done_doneflag", 32'(done), 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_done_busy", 32'(busy), 32'd0);
        check("cxl_done_hi", hi, 32'd2);
        check("cxl_done_lo", lo, 32'd14);
        $display("cancel in DONE: hi=%h lo=%h", hi, lo);

        // start together with cancel in IDLE does nothing.
        start = 1'b1; cancel = 1'b1; op = 3'b100; a = 32'hAAAA_AAAA;
        tick();
        check("cxl_idle_mthi", hi, 32'd2);
        op = 3'b010; a = 32'd9; b = 32'd3;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cxl_idle_div_busy", 32'(busy), 32'd0);
        tick();
        check("cxl_idle_busy2", 32'(busy), 32'd0);
        check("cxl_idle_lo", lo, 32'd14);
        $display("start+cancel in IDLE: busy=%0d hi=%h lo=%h", busy, hi, lo);

        // Reserved op is ignored.
        start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd1;
        tick();
        start = 1'b0;
        check("reserved_busy", 32'(busy), 32'd0);
        $display("reserved op: busy=%0d", busy);

        // Reset during RUN cycle 20.
        start = 1'b1; op = 3'b000; a = 32'd12345; b = 32'd678;
        tick();
        start = 1'b0;
        repeat (19) tick();
        resetn = 1'b0;
        tick();
        check("rst_run_busy", 32'(busy), 32'd0);
        check("rst_run_done", 32'(done), 32'd0);
        check("rst_run_hi", hi, 32'd0);
        check("rst_run_lo", lo, 32'd0);
        resetn = 1'b1;
        tick();
        $display("reset in RUN: busy=%0d hi=%h lo=%h", busy, hi, lo);

        do_op("divu_after_rst", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
